// File: rtl/host_bus_master.sv
// host_bus_master
//
// Initiator for the asynchronous-style host bus (nCS/nOE/nWE, 21-bit address,
// 16-bit data). A valid/ready request is turned into a timed bus cycle of
// SETUP_CYC / ACCESS_CYC / HOLD_CYC / TURN_CYC clocks. Completion is reported
// by a one-cycle rsp_valid pulse. On reads, rsp_rdata carries the data.
//
// Handshake: a request transfers on any rising clk edge where
// req_valid && req_ready are both high. req_ready is high only in IDLE and is
// decoded from the state register, so nothing combinational runs from
// req_valid to the bus. Request fields are ignored on all other edges.
// rsp_valid is a single-cycle strobe with no back-pressure.
//
// Optional build macro HOST_BUS_WAIT_EN adds the following:
//   - input HOST_nWAIT (active low). It stretches the ACCESS phase.
//   - output rsp_err. It flags an access aborted after more than WAIT_TMO
//     consecutive stall cycles; in that case rsp_rdata is 16'hDEAD.
//
// Ports:
//   clk, nRESET          clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_wr               1 = write, 0 = read
//   req_addr, req_wdata  request address / write data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            read data (valid with rsp_valid on reads)
//   busy                 state != IDLE
//   HOST_nCS/nOE/nWE     bus strobes, active low, registered
//   HOST_ADD, HOST_DO    bus address / write data, registered
//   HOST_DI              read data from the responder
//   HOST_nWAIT, rsp_err  only with HOST_BUS_WAIT_EN

module host_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1
`ifdef HOST_BUS_WAIT_EN
  ,
  parameter int WAIT_TMO   = 255
`endif
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [20:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        HOST_nCS,
  output logic        HOST_nOE,
  output logic        HOST_nWE,
  output logic [20:0] HOST_ADD,
  output logic [15:0] HOST_DO,
  input  logic [15:0] HOST_DI
`ifdef HOST_BUS_WAIT_EN
  ,
  input  logic        HOST_nWAIT,
  output logic        rsp_err
`endif
);

  localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_HT  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int MAX_CYC = (MAX_SA > MAX_HT) ? MAX_SA : MAX_HT;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  // S_START is the cycle between the accept edge and driving the bus. The
  // latched request reaches the pins one edge later, which keeps the bus
  // fully registered off the request capture.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_HOLD   = 3'd4,
    S_TURN   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [20:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ncs_q, ncs_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic [20:0] add_q, add_d;
  logic [15:0] do_q, do_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

`ifdef HOST_BUS_WAIT_EN
  localparam int STALL_W = (WAIT_TMO < 2) ? 1 : $clog2(WAIT_TMO + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ncs_d       = ncs_q;
    noe_d       = noe_q;
    nwe_d       = nwe_q;
    add_d       = add_q;
    do_d        = do_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef HOST_BUS_WAIT_EN
    stall_d     = stall_q;
    rsp_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_START;
        end
      end

      S_START: begin
        add_d = addr_q;
        // Reads leave HOST_DO at its previous value.
        if (wr_q) begin
          do_d = wdata_q;
        end
        ncs_d   = 1'b0;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
        state_d = S_SETUP;
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          if (wr_q) begin
            nwe_d = 1'b0;
          end else begin
            noe_d = 1'b0;
          end
          cnt_d   = CNT_W'(ACCESS_CYC - 1);
          state_d = S_ACCESS;
`ifdef HOST_BUS_WAIT_EN
          stall_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ACCESS: begin
`ifdef HOST_BUS_WAIT_EN
        // The phase counter freezes while the responder holds nWAIT low.
        // stall_q counts consecutive stalled edges. The abort fires on the
        // stalled edge after WAIT_TMO have already been counted.
        stall_d = '0;
        if (!HOST_nWAIT) begin
          if (stall_q == STALL_W'(WAIT_TMO)) begin
            noe_d       = 1'b1;
            nwe_d       = 1'b1;
            rsp_rdata_d = 16'hDEAD;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cnt_d       = CNT_W'(HOLD_CYC - 1);
            state_d     = S_HOLD;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else
`endif
        if (cnt_q == '0) begin
          noe_d = 1'b1;
          nwe_d = 1'b1;
          if (!wr_q) begin
            rsp_rdata_d = HOST_DI;
          end
          rsp_valid_d = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYC - 1);
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          ncs_d   = 1'b1;
          cnt_d   = CNT_W'(TURN_CYC - 1);
          state_d = S_TURN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        ncs_d   = 1'b1;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ncs_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      add_q       <= '0;
      do_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef HOST_BUS_WAIT_EN
      stall_q     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ncs_q       <= ncs_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      add_q       <= add_d;
      do_q        <= do_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef HOST_BUS_WAIT_EN
      stall_q     <= stall_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign HOST_nCS  = ncs_q;
  assign HOST_nOE  = noe_q;
  assign HOST_nWE  = nwe_q;
  assign HOST_ADD  = add_q;
  assign HOST_DO   = do_q;
`ifdef HOST_BUS_WAIT_EN
  assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_host_bus_master.sv
// Bench for host_bus_master. It uses the following:
//   - a default-timing instance driven against a small register responder;
//   - a second instance with 3/4/2/2 phase timing for phase-length checks.
//
// Responder model behaviour:
//   - It returns mem[addr] on HOST_DI one clk after nOE is seen low.
//   - It commits a write only once nWE has been seen low on two consecutive
//     edges, so a strobe cut short after one cycle does not commit.
module tb_host_bus_master;

  logic        clk;
  logic        nreset;
  logic        req_valid, req_wr, req_ready, rsp_valid, busy;
  logic [20:0] req_addr, host_add;
  logic [15:0] req_wdata, rsp_rdata, host_do, host_di;
  logic        host_ncs, host_noe, host_nwe;

  logic        req2_valid, req2_wr, req2_ready, rsp2_valid, busy2;
  logic [20:0] req2_addr, host2_add;
  logic [15:0] req2_wdata, rsp2_rdata, host2_do;
  logic        host2_ncs, host2_noe, host2_nwe;
  wire  [15:0] host2_di = 16'h0000;

`ifdef HOST_BUS_WAIT_EN
  logic        host_nwait, rsp_err, rsp2_err;
  wire         host2_nwait = 1'b1;
  int          wait_len;
  int          stall_cnt;
`endif

  int vecs;
  int errs;

  // Responder model
  logic [15:0] mem [0:255];
  logic        mem_load;
  logic        we_seen;

  // Results of the most recent run_txn
  int          r_lat, r_wait, r_ncs_lo, r_nwe_lo, r_noe_lo, r_rsp_n;
  int          r_setup, r_acc, r_hold, r_tail, r_lead;
  logic [15:0] r_rdata, r_do;
  logic [20:0] r_add;
  logic        r_err, r_both, r_tmo;

  host_bus_master dut (
    .clk(clk), .nRESET(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .HOST_nCS(host_ncs), .HOST_nOE(host_noe), .HOST_nWE(host_nwe),
    .HOST_ADD(host_add), .HOST_DO(host_do), .HOST_DI(host_di)
`ifdef HOST_BUS_WAIT_EN
    , .HOST_nWAIT(host_nwait), .rsp_err(rsp_err)
`endif
  );

  host_bus_master #(.SETUP_CYC(3), .ACCESS_CYC(4), .HOLD_CYC(2), .TURN_CYC(2)) dut_slow (
    .clk(clk), .nRESET(nreset),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_wr(req2_wr),
    .req_addr(req2_addr), .req_wdata(req2_wdata),
    .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata), .busy(busy2),
    .HOST_nCS(host2_ncs), .HOST_nOE(host2_noe), .HOST_nWE(host2_nwe),
    .HOST_ADD(host2_add), .HOST_DO(host2_do), .HOST_DI(host2_di)
`ifdef HOST_BUS_WAIT_EN
    , .HOST_nWAIT(host2_nwait), .rsp_err(rsp2_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h92] <= 16'h002A;
      mem[8'h10] <= 16'h1111;
      we_seen    <= 1'b0;
      host_di    <= 16'h0000;
    end else begin
      if (!host_ncs && !host_nwe) begin
        if (we_seen) mem[host_add[7:0]] <= host_do;
        we_seen <= 1'b1;
      end else begin
        we_seen <= 1'b0;
      end
      if (!host_ncs && !host_noe) host_di <= mem[host_add[7:0]];
    end
  end

`ifdef HOST_BUS_WAIT_EN
  // Holds nWAIT low for wait_len edges counted from the first cycle nOE is low.
  always @(negedge clk) begin
    if (host_noe) begin
      stall_cnt  = 0;
      host_nwait = 1'b1;
    end else begin
      host_nwait = !(stall_cnt < wait_len);
      stall_cnt  = stall_cnt + 1;
    end
  end
`endif

  // Driver task: it must be called right after a negedge.
  //
  // It presents one request on instance sel (0 = default timing, 1 = slow),
  // waits for the accept edge and then samples every negedge until req_ready.
  //
  // Sample c is taken at the negedge after accept edge + c. The ready sample
  // therefore gives the accept-to-ready edge count.
  //
  // Phase counts:
  //   r_lead  samples with nCS high before the bus starts;
  //   r_tail  samples with nCS high after HOLD, including the ready sample.
  //
  // If nxt_v is set, the next request is left on the inputs after the accept.
  task automatic run_txn(input bit sel, input bit wr, input logic [20:0] addr,
                         input logic [15:0] wdata, input bit nxt_v, input bit nxt_wr,
                         input logic [20:0] nxt_addr, input logic [15:0] nxt_wdata);
    logic s_ncs, s_noe, s_nwe, s_rsp, s_rdy, s_err, strobe;
    logic [15:0] s_rdata, s_do;
    logic [20:0] s_add;
    int phase;
    r_lat = -1; r_wait = 0; r_ncs_lo = 0; r_nwe_lo = 0; r_noe_lo = 0; r_rsp_n = 0;
    r_setup = 0; r_acc = 0; r_hold = 0; r_tail = 0; r_lead = 0;
    r_rdata = 16'hxxxx; r_do = 16'hxxxx; r_add = 21'hxxxxx; r_err = 1'b0;
    r_both = 1'b0; r_tmo = 1'b1; phase = 0;
    if (sel) begin
      req2_valid = 1'b1; req2_wr = wr; req2_addr = addr; req2_wdata = wdata;
    end else begin
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    end
    while (!(sel ? req2_ready : req_ready) && r_wait < 50) begin
      @(negedge clk);
      r_wait++;
    end
    @(posedge clk);
    #1;
    if (sel) begin
      req2_valid = 1'b0; req2_wr = 1'($urandom_range(0, 1));
      req2_addr = 21'($urandom); req2_wdata = 16'($urandom);
    end else if (nxt_v) begin
      req_valid = 1'b1; req_wr = nxt_wr; req_addr = nxt_addr; req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'b0; req_wr = 1'($urandom_range(0, 1));
      req_addr = 21'($urandom); req_wdata = 16'($urandom);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      s_ncs   = sel ? host2_ncs : host_ncs;
      s_noe   = sel ? host2_noe : host_noe;
      s_nwe   = sel ? host2_nwe : host_nwe;
      s_rsp   = sel ? rsp2_valid : rsp_valid;
      s_rdy   = sel ? req2_ready : req_ready;
      s_rdata = sel ? rsp2_rdata : rsp_rdata;
      s_add   = sel ? host2_add : host_add;
      s_do    = sel ? host2_do : host_do;
`ifdef HOST_BUS_WAIT_EN
      s_err   = sel ? rsp2_err : rsp_err;
`else
      s_err   = 1'b0;
`endif
      if (!s_noe && !s_nwe) r_both = 1'b1;
      if (!s_ncs) r_ncs_lo++;
      if (!s_nwe) r_nwe_lo++;
      if (!s_noe) r_noe_lo++;
      if (s_rsp) begin
        r_rsp_n++; r_rdata = s_rdata; r_err = s_err;
      end
      strobe = !s_noe || !s_nwe;
      if (strobe) begin
        r_add = s_add; r_do = s_do; phase = 2; r_acc++;
      end else if (!s_ncs) begin
        if (phase <= 1) begin phase = 1; r_setup++; end
        else begin phase = 3; r_hold++; end
      end else begin
        if (phase == 0) r_lead++;
        else begin phase = 4; r_tail++; end
      end
      if (s_rdy) begin
        r_lat = c; r_tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    vecs++; if (host_ncs !== 1'b1) begin errs++; $display("FAIL rst_ncs: got %b expected 1", host_ncs); end
    vecs++; if (host_noe !== 1'b1) begin errs++; $display("FAIL rst_noe: got %b expected 1", host_noe); end
    vecs++; if (host_nwe !== 1'b1) begin errs++; $display("FAIL rst_nwe: got %b expected 1", host_nwe); end
    vecs++; if (host_add !== 21'h0) begin errs++; $display("FAIL rst_add: got %h expected 0", host_add); end
    vecs++; if (host_do !== 16'h0) begin errs++; $display("FAIL rst_do: got %h expected 0", host_do); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    vecs++; if (rsp_rdata !== 16'h0) begin errs++; $display("FAIL rst_rdata: got %h expected 0", rsp_rdata); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_idle;
    int active;
    active = 0;
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_wr = 1'($urandom_range(0, 1)); req_addr = 21'($urandom); req_wdata = 16'($urandom);
      @(negedge clk);
      if (!host_ncs || !host_noe || !host_nwe || busy || rsp_valid) active++;
    end
    vecs++; if (active !== 0) begin errs++; $display("FAIL idle_no_activity: got %0d active cycles expected 0", active); end
  endtask

  task automatic test_write;
    run_txn(0, 1'b1, 21'h00020, 16'h0005, 0, 0, '0, '0);
    vecs++; if (r_tmo !== 1'b0) begin errs++; $display("FAIL wr_timeout: got %b expected 0", r_tmo); end
    vecs++; if (r_lat !== 6) begin errs++; $display("FAIL wr_latency: got %0d expected 6", r_lat); end
    vecs++; if (r_ncs_lo !== 4) begin errs++; $display("FAIL wr_ncs_len: got %0d expected 4", r_ncs_lo); end
    vecs++; if (r_nwe_lo !== 2) begin errs++; $display("FAIL wr_nwe_len: got %0d expected 2", r_nwe_lo); end
    vecs++; if (r_noe_lo !== 0) begin errs++; $display("FAIL wr_noe_len: got %0d expected 0", r_noe_lo); end
    vecs++; if (r_add !== 21'h00020) begin errs++; $display("FAIL wr_addr: got %h expected 00020", r_add); end
    vecs++; if (r_do !== 16'h0005) begin errs++; $display("FAIL wr_data: got %h expected 0005", r_do); end
    vecs++; if (r_rsp_n !== 1) begin errs++; $display("FAIL wr_rsp_count: got %0d expected 1", r_rsp_n); end
    vecs++; if (r_rdata !== 16'h0000) begin errs++; $display("FAIL wr_rdata_kept: got %h expected 0000", r_rdata); end
    vecs++; if (mem[8'h20] !== 16'h0005) begin errs++; $display("FAIL wr_led_reg: got %h expected 0005", mem[8'h20]); end
    vecs++; if (r_setup !== 1 || r_acc !== 2 || r_hold !== 1 || r_tail !== 2)
      begin errs++; $display("FAIL wr_phases: got %0d/%0d/%0d/%0d expected 1/2/1/2", r_setup, r_acc, r_hold, r_tail); end
  endtask

  task automatic test_read;
    run_txn(0, 1'b0, 21'h00092, 16'hFFFF, 0, 0, '0, '0);
    vecs++; if (r_lat !== 6) begin errs++; $display("FAIL rd_latency: got %0d expected 6", r_lat); end
    vecs++; if (r_noe_lo !== 2) begin errs++; $display("FAIL rd_noe_len: got %0d expected 2", r_noe_lo); end
    vecs++; if (r_nwe_lo !== 0) begin errs++; $display("FAIL rd_nwe_len: got %0d expected 0", r_nwe_lo); end
    vecs++; if (r_rsp_n !== 1) begin errs++; $display("FAIL rd_rsp_count: got %0d expected 1", r_rsp_n); end
    vecs++; if (r_rdata !== 16'h002A) begin errs++; $display("FAIL rd_data: got %h expected 002A", r_rdata); end
    vecs++; if (r_add !== 21'h00092) begin errs++; $display("FAIL rd_addr: got %h expected 00092", r_add); end
    vecs++; if (r_do !== 16'h0005) begin errs++; $display("FAIL rd_do_held: got %h expected 0005", r_do); end
  endtask

  // Between the two transactions nCS stays high for the TURN phase, the IDLE
  // accept cycle and the request-latch cycle.
  task automatic test_back_to_back;
    int tail1;
    run_txn(0, 1'b1, 21'h00030, 16'h0034, 1, 1'b0, 21'h00030, 16'h9999);
    tail1 = r_tail;
    vecs++; if (r_rsp_n !== 1 || r_nwe_lo !== 2) begin errs++; $display("FAIL b2b_wr: got rsp %0d nwe %0d expected 1 2", r_rsp_n, r_nwe_lo); end
    vecs++; if (r_rdata !== 16'h002A) begin errs++; $display("FAIL b2b_wr_rdata_kept: got %h expected 002A", r_rdata); end
    run_txn(0, 1'b0, 21'h00030, 16'h9999, 0, 0, '0, '0);
    vecs++; if (r_wait !== 0) begin errs++; $display("FAIL b2b_first_idle_accept: got %0d wait cycles expected 0", r_wait); end
    vecs++; if (tail1 + r_lead !== 3) begin errs++; $display("FAIL b2b_ncs_gap: got %0d expected 3", tail1 + r_lead); end
    vecs++; if (r_rdata !== 16'h0034) begin errs++; $display("FAIL b2b_rd_data: got %h expected 0034", r_rdata); end
    vecs++; if (r_both !== 1'b0) begin errs++; $display("FAIL b2b_both_strobes: got %b expected 0", r_both); end
  endtask

  task automatic test_reset_mid;
    int rsp_seen;
    rsp_seen = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 21'h00010; req_wdata = 16'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    vecs++; if (host_nwe !== 1'b0) begin errs++; $display("FAIL rm_strobe_active: got %b expected 0", host_nwe); end
    nreset = 1'b0;
    #1;
    vecs++; if (host_nwe !== 1'b1) begin errs++; $display("FAIL rm_nwe_async: got %b expected 1", host_nwe); end
    vecs++; if (host_ncs !== 1'b1) begin errs++; $display("FAIL rm_ncs_async: got %b expected 1", host_ncs); end
    vecs++; if (busy !== 1'b0 || req_ready !== 1'b1)
      begin errs++; $display("FAIL rm_idle: got busy %b ready %b expected 0 1", busy, req_ready); end
    @(negedge clk);
    if (rsp_valid) rsp_seen++;
    nreset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    vecs++; if (rsp_seen !== 0) begin errs++; $display("FAIL rm_no_rsp: got %0d expected 0", rsp_seen); end
    vecs++; if (mem[8'h10] !== 16'h1111) begin errs++; $display("FAIL rm_reg_unchanged: got %h expected 1111", mem[8'h10]); end
    run_txn(0, 1'b0, 21'h00010, 16'h0000, 0, 0, '0, '0);
    vecs++; if (r_rdata !== 16'h1111) begin errs++; $display("FAIL rm_readback: got %h expected 1111", r_rdata); end
  endtask

  task automatic test_slow_timing;
    run_txn(1, 1'b1, 21'h00031, 16'h00A5, 0, 0, '0, '0);
    vecs++; if (r_setup !== 3) begin errs++; $display("FAIL slow_setup: got %0d expected 3", r_setup); end
    vecs++; if (r_acc !== 4) begin errs++; $display("FAIL slow_access: got %0d expected 4", r_acc); end
    vecs++; if (r_hold !== 2) begin errs++; $display("FAIL slow_hold: got %0d expected 2", r_hold); end
    vecs++; if (r_tail !== 3) begin errs++; $display("FAIL slow_turn: got %0d expected 3", r_tail); end
    vecs++; if (r_lat !== 12) begin errs++; $display("FAIL slow_latency: got %0d expected 12", r_lat); end
    vecs++; if (r_rsp_n !== 1 || r_do !== 16'h00A5)
      begin errs++; $display("FAIL slow_resp: got rsp %0d do %h expected 1 00A5", r_rsp_n, r_do); end
  endtask

`ifdef HOST_BUS_WAIT_EN
  task automatic test_wait;
    wait_len = 10;
    run_txn(0, 1'b0, 21'h00092, 16'h0000, 0, 0, '0, '0);
    vecs++; if (r_noe_lo !== 12) begin errs++; $display("FAIL wait_noe_len: got %0d expected 12", r_noe_lo); end
    vecs++; if (r_rdata !== 16'h002A || r_err !== 1'b0)
      begin errs++; $display("FAIL wait_data: got %h err %b expected 002A 0", r_rdata, r_err); end
    vecs++; if (r_lat !== 16) begin errs++; $display("FAIL wait_latency: got %0d expected 16", r_lat); end
    wait_len = 1000000;
    run_txn(0, 1'b0, 21'h00092, 16'h0000, 0, 0, '0, '0);
    wait_len = 0;
    vecs++; if (r_noe_lo !== 256) begin errs++; $display("FAIL tmo_noe_len: got %0d expected 256", r_noe_lo); end
    vecs++; if (r_err !== 1'b1) begin errs++; $display("FAIL tmo_err: got %b expected 1", r_err); end
    vecs++; if (r_rdata !== 16'hDEAD) begin errs++; $display("FAIL tmo_rdata: got %h expected DEAD", r_rdata); end
    vecs++; if (r_rsp_n !== 1 || r_tmo !== 1'b0)
      begin errs++; $display("FAIL tmo_rsp: got rsp %0d tmo %b expected 1 0", r_rsp_n, r_tmo); end
  endtask
`endif

  initial begin
    vecs = 0; errs = 0;
    nreset = 1'b0; mem_load = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    req2_valid = 1'b0; req2_wr = 1'b0; req2_addr = '0; req2_wdata = '0;
`ifdef HOST_BUS_WAIT_EN
    wait_len = 0;
`endif
    repeat (3) @(negedge clk);
    test_reset;
    mem_load = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    test_idle;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_mid;
    test_slow_timing;
`ifdef HOST_BUS_WAIT_EN
    test_wait;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
